// File: rtl/pyon_pkg.sv
// Shared definitions for the box plotting path: screen geometry, field
// widths, colour constants and the box request record.
package pyon_pkg;

  localparam int unsigned SCREEN_W = 160;
  localparam int unsigned SCREEN_H = 120;
  localparam int unsigned X_W      = 8;
  localparam int unsigned Y_W      = 7;
  localparam int unsigned COL_W    = 3;

  localparam logic [COL_W-1:0] WHITE = 3'b111;
  localparam logic [COL_W-1:0] BLACK = 3'b000;

  typedef struct packed {
    logic [X_W-1:0]   x;
    logic [Y_W-1:0]   y;
    logic [COL_W-1:0] colour;
  } box_req_t;

  typedef enum logic {
    ST_IDLE,
    ST_DRAW
  } plot_state_e;

  // True when a pixel lies inside the visible screen area.
  function automatic logic on_screen(input logic [X_W-1:0] x, input logic [Y_W-1:0] y);
    return (32'(x) < SCREEN_W) && (32'(y) < SCREEN_H);
  endfunction

endpackage

// File: rtl/box_req_fifo.sv
// Small synchronous request FIFO. Count-based full/empty; the head entry is
// read from registered state, so a same-edge push and pop sees the old head.
module box_req_fifo
  import pyon_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     push_i,
  input  box_req_t wr_data_i,
  input  logic     pop_i,
  output box_req_t rd_data_o,
  output logic     full_o,
  output logic     empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  box_req_t       mem_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q;
  logic [AW-1:0]  rd_ptr_q;
  logic [AW:0]    count_q;

  // Storage array: written on push, no reset needed.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= wr_data_i;
  end

  // Pointers and occupancy count; power-of-two depth lets pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign full_o    = (count_q == (AW+1)'(DEPTH));
  assign empty_o   = (count_q == '0);

endmodule

// File: rtl/box_plotter.sv
// Expands buffered box requests into a row-major raster of single-pixel
// writes, one per clock, with screen clipping and back-to-back box reload.
module box_plotter
  import pyon_pkg::*;
#(
  parameter int unsigned BOX_W      = 4,
  parameter int unsigned BOX_H      = 3,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [X_W-1:0]   in_x,
  input  logic [Y_W-1:0]   in_y,
  input  logic [COL_W-1:0] in_colour,
  output logic [X_W-1:0]   vga_x,
  output logic [Y_W-1:0]   vga_y,
  output logic [COL_W-1:0] vga_colour,
  output logic             plot,
  output logic             box_done,
  output logic             busy,
  output logic             overflow
);

  plot_state_e      state_q, state_d;
  logic [3:0]       cx_q, cx_d;
  logic [3:0]       cy_q, cy_d;
  logic [X_W-1:0]   base_x_q, base_x_d;
  logic [Y_W-1:0]   base_y_q, base_y_d;
  logic [COL_W-1:0] col_q, col_d;
  logic             overflow_q;

  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;
  logic             last_px;
  box_req_t         head;

  assign push = in_valid && !fifo_full;

  box_req_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push_i    (push),
    .wr_data_i ('{x: in_x, y: in_y, colour: in_colour}),
    .pop_i     (pop),
    .rd_data_o (head),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  assign last_px = (state_q == ST_DRAW) && (cx_q == 4'(BOX_W-1)) && (cy_q == 4'(BOX_H-1));

  // Next-state: pop/reload the raster, step counters in row-major order.
  // Counters hold at the last pixel when going idle so the pixel outputs hold.
  always_comb begin
    state_d  = state_q;
    cx_d     = cx_q;
    cy_d     = cy_q;
    base_x_d = base_x_q;
    base_y_d = base_y_q;
    col_d    = col_q;
    pop      = 1'b0;
    if ((state_q == ST_IDLE || last_px) && !fifo_empty) begin
      pop      = 1'b1;
      state_d  = ST_DRAW;
      base_x_d = head.x;
      base_y_d = head.y;
      col_d    = head.colour;
      cx_d     = '0;
      cy_d     = '0;
    end else if (last_px) begin
      state_d = ST_IDLE;
    end else if (state_q == ST_DRAW) begin
      if (cx_q == 4'(BOX_W-1)) begin
        cx_d = '0;
        cy_d = cy_q + 1'b1;
      end else begin
        cx_d = cx_q + 1'b1;
      end
    end
  end

  // State, raster and sticky overflow registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cx_q       <= '0;
      cy_q       <= '0;
      base_x_q   <= '0;
      base_y_q   <= '0;
      col_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cx_q       <= cx_d;
      cy_q       <= cy_d;
      base_x_q   <= base_x_d;
      base_y_q   <= base_y_d;
      col_q      <= col_d;
      if (in_valid && fifo_full) overflow_q <= 1'b1;
    end
  end

  assign vga_x      = base_x_q + X_W'(cx_q);
  assign vga_y      = base_y_q + Y_W'(cy_q);
  assign vga_colour = col_q;
  assign plot       = (state_q == ST_DRAW) && on_screen(vga_x, vga_y);
  assign box_done   = last_px;
  assign busy       = (state_q == ST_DRAW) || !fifo_empty;
  assign in_ready   = !fifo_full;
  assign overflow   = overflow_q;

endmodule
